// File: rtl/ifid_hazard_responder.sv
// Consumer side of the hazard-detection interface: owns PC, IF/ID and the ID/EX
// control-bubble register, buffers redirects seen while frozen, keeps stall stats.
module ifid_hazard_responder #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned CTRL_W    = 12,
  parameter int unsigned MAX_STALL = 8,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              PCWrite,
  input  logic              IFID_Write,
  input  logic              IF_Flush,
  input  logic              stall_IDEX,
  input  logic              Jump,
  input  logic              BranchTaken,
  input  logic [31:0]       JumpTarget,
  input  logic [31:0]       BranchTarget,
  input  logic [31:0]       Instr_in,
  input  logic [CTRL_W-1:0] ID_Ctrl,
  output logic [31:0]       PC,
  output logic [31:0]       IFID_Instr,
  output logic [31:0]       IFID_PCPlus4,
  output logic              IFID_Valid,
  output logic [CTRL_W-1:0] IDEX_Ctrl,
  output logic              RedirectPending,
  output logic [CNT_W-1:0]  StallCount,
  output logic [CNT_W-1:0]  FlushCount,
  output logic              StallTimeout
);

  localparam int unsigned RUN_W = (MAX_STALL < 2) ? 1 : $clog2(MAX_STALL + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_STALL);

  logic [31:0]       r_pc;
  logic [31:0]       r_ifid_instr;
  logic [31:0]       r_ifid_pcp4;
  logic              r_ifid_valid;
  logic [CTRL_W-1:0] r_idex_ctrl;
  logic              r_redir_pend;
  logic [31:0]       r_redir_tgt;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_flush_cnt;
  logic [RUN_W-1:0]  r_run;
  logic              r_timeout;

  logic              w_req;
  logic [31:0]       w_req_tgt;
  logic [31:0]       w_pc_plus4;
  logic [RUN_W-1:0]  w_run_inc;

  assign w_req      = Jump | BranchTaken;
  assign w_req_tgt  = Jump ? JumpTarget : BranchTarget;
  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_run_inc  = r_run + 1'b1;

  // PC and the redirect buffer: a live request always wins over a buffered one
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_pc         <= RESET_PC;
      r_redir_pend <= 1'b0;
      r_redir_tgt  <= '0;
    end else if (PCWrite) begin
      r_redir_pend <= 1'b0;
      if (w_req)             r_pc <= w_req_tgt;
      else if (r_redir_pend) r_pc <= r_redir_tgt;
      else                   r_pc <= w_pc_plus4;
    end else if (w_req) begin
      r_redir_pend <= 1'b1;
      r_redir_tgt  <= w_req_tgt;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_ifid_instr <= '0;
      r_ifid_pcp4  <= '0;
      r_ifid_valid <= 1'b0;
    end else if (IF_Flush) begin
      r_ifid_instr <= '0;
      r_ifid_pcp4  <= '0;
      r_ifid_valid <= 1'b0;
    end else if (IFID_Write) begin
      r_ifid_instr <= Instr_in;
      r_ifid_pcp4  <= w_pc_plus4;
      r_ifid_valid <= 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst)                            r_idex_ctrl <= '0;
    else if (stall_IDEX || !r_ifid_valid) r_idex_ctrl <= '0;
    else                                  r_idex_ctrl <= ID_Ctrl;
  end

  // Statistics saturate; the run counter saturates at MAX_STALL so it cannot wrap
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
      r_run       <= '0;
      r_timeout   <= 1'b0;
    end else begin
      if (!PCWrite && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (IF_Flush && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + 1'b1;
      if (PCWrite) begin
        r_run <= '0;
      end else if (r_run != RUN_MAX) begin
        r_run <= w_run_inc;
        if (w_run_inc == RUN_MAX) r_timeout <= 1'b1;
      end
    end
  end

  assign PC              = r_pc;
  assign IFID_Instr      = r_ifid_instr;
  assign IFID_PCPlus4    = r_ifid_pcp4;
  assign IFID_Valid      = r_ifid_valid;
  assign IDEX_Ctrl       = r_idex_ctrl;
  assign RedirectPending = r_redir_pend;
  assign StallCount      = r_stall_cnt;
  assign FlushCount      = r_flush_cnt;
  assign StallTimeout    = r_timeout;

endmodule

// File: tb/tb_ifid_hazard_responder.sv
// Directed bench for ifid_hazard_responder: PC sequencing, stalls, buffered
// redirects, flush, wrap, watchdog and asynchronous reset.
module tb_ifid_hazard_responder;

  localparam int unsigned CTRL_W = 12;
  localparam int unsigned CNT_W  = 16;

  logic              Clk = 1'b0;
  logic              Rst;
  logic              PCWrite, IFID_Write, IF_Flush, stall_IDEX, Jump, BranchTaken;
  logic [31:0]       JumpTarget, BranchTarget, Instr_in;
  logic [CTRL_W-1:0] ID_Ctrl;
  logic [31:0]       PC, IFID_Instr, IFID_PCPlus4;
  logic              IFID_Valid, RedirectPending, StallTimeout;
  logic [CTRL_W-1:0] IDEX_Ctrl;
  logic [CNT_W-1:0]  StallCount, FlushCount;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  ifid_hazard_responder #(
    .RESET_PC (32'h0000_0000),
    .CTRL_W   (CTRL_W),
    .MAX_STALL(8),
    .CNT_W    (CNT_W)
  ) dut (
    .Clk            (Clk),
    .Rst            (Rst),
    .PCWrite        (PCWrite),
    .IFID_Write     (IFID_Write),
    .IF_Flush       (IF_Flush),
    .stall_IDEX     (stall_IDEX),
    .Jump           (Jump),
    .BranchTaken    (BranchTaken),
    .JumpTarget     (JumpTarget),
    .BranchTarget   (BranchTarget),
    .Instr_in       (Instr_in),
    .ID_Ctrl        (ID_Ctrl),
    .PC             (PC),
    .IFID_Instr     (IFID_Instr),
    .IFID_PCPlus4   (IFID_PCPlus4),
    .IFID_Valid     (IFID_Valid),
    .IDEX_Ctrl      (IDEX_Ctrl),
    .RedirectPending(RedirectPending),
    .StallCount     (StallCount),
    .FlushCount     (FlushCount),
    .StallTimeout   (StallTimeout)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int unsigned n = 1);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic idle_inputs();
    PCWrite = 1'b0; IFID_Write = 1'b0; IF_Flush = 1'b0; stall_IDEX = 1'b0;
    Jump = 1'b0; BranchTaken = 1'b0;
    JumpTarget = '0; BranchTarget = '0; Instr_in = '0; ID_Ctrl = '0;
  endtask

  task automatic do_reset();
    Rst = 1'b0;
    step(2);
    Rst = 1'b1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_pc"},    PC, 32'h0);
    chk({tag, "_instr"}, IFID_Instr, 32'h0);
    chk({tag, "_pcp4"},  IFID_PCPlus4, 32'h0);
    chk({tag, "_valid"}, 32'(IFID_Valid), 32'h0);
    chk({tag, "_ctrl"},  32'(IDEX_Ctrl), 32'h0);
    chk({tag, "_pend"},  32'(RedirectPending), 32'h0);
    chk({tag, "_scnt"},  32'(StallCount), 32'h0);
    chk({tag, "_fcnt"},  32'(FlushCount), 32'h0);
    chk({tag, "_tmo"},   32'(StallTimeout), 32'h0);
  endtask

  initial begin
    idle_inputs();
    do_reset();
    chk_reset_state("rst");

    // Straight-line fetch
    PCWrite = 1; IFID_Write = 1; Instr_in = 32'h8C22_0004; ID_Ctrl = 12'h5A5;
    step();
    chk("run1_pc", PC, 32'h4);
    chk("run1_instr", IFID_Instr, 32'h8C22_0004);
    chk("run1_pcp4", IFID_PCPlus4, 32'h4);
    chk("run1_valid", 32'(IFID_Valid), 32'h1);
    chk("run1_ctrl_bubble", 32'(IDEX_Ctrl), 32'h0);
    step();
    chk("run2_pc", PC, 32'h8);
    chk("run2_ctrl", 32'(IDEX_Ctrl), 32'h5A5);

    // One-cycle load-use stall
    PCWrite = 0; IFID_Write = 0; stall_IDEX = 1; Instr_in = 32'h1234_5678;
    step();
    chk("stall_pc", PC, 32'h8);
    chk("stall_instr", IFID_Instr, 32'h8C22_0004);
    chk("stall_pcp4", IFID_PCPlus4, 32'h8);
    chk("stall_ctrl", 32'(IDEX_Ctrl), 32'h0);
    chk("stall_cnt1", 32'(StallCount), 32'h1);
    PCWrite = 1; IFID_Write = 1; stall_IDEX = 0;
    step();
    chk("release_pc", PC, 32'hC);
    chk("release_instr", IFID_Instr, 32'h1234_5678);
    chk("release_pcp4", IFID_PCPlus4, 32'hC);
    step();
    chk("pc16", PC, 32'h10);

    // Branch arrives while frozen, is buffered, applied on release
    PCWrite = 0; IFID_Write = 0; BranchTaken = 1; BranchTarget = 32'h40;
    step();
    chk("br_pend", 32'(RedirectPending), 32'h1);
    chk("br_pc_hold", PC, 32'h10);
    BranchTaken = 0; BranchTarget = 32'hDEAD_0000;
    step(2);
    chk("br_pc_hold3", PC, 32'h10);
    chk("br_scnt", 32'(StallCount), 32'h4);
    PCWrite = 1; IFID_Write = 1;
    step();
    chk("br_pc_applied", PC, 32'h40);
    chk("br_pend_clr", 32'(RedirectPending), 32'h0);
    chk("br_no_tmo", 32'(StallTimeout), 32'h0);

    // Jump beats branch; flush beats IFID_Write
    Jump = 1; JumpTarget = 32'h100; BranchTaken = 1; BranchTarget = 32'h80;
    IF_Flush = 1; Instr_in = 32'hFFFF_0000;
    step();
    chk("jmp_pc", PC, 32'h100);
    chk("jmp_valid", 32'(IFID_Valid), 32'h0);
    chk("jmp_instr", IFID_Instr, 32'h0);
    chk("jmp_pcp4", IFID_PCPlus4, 32'h0);
    chk("jmp_fcnt", 32'(FlushCount), 32'h1);
    Jump = 0; BranchTaken = 0; IF_Flush = 0;
    step();
    chk("post_flush_ctrl", 32'(IDEX_Ctrl), 32'h0);
    chk("post_flush_pc", PC, 32'h104);

    // PC wrap at the top of the address space
    Jump = 1; JumpTarget = 32'hFFFF_FFFC;
    step();
    chk("wrap_pre", PC, 32'hFFFF_FFFC);
    Jump = 0;
    step();
    chk("wrap_pc", PC, 32'h0);
    chk("wrap_pcp4", IFID_PCPlus4, 32'h0);

    // Newer frozen request overwrites older; live request supersedes buffer
    PCWrite = 0; IFID_Write = 0; BranchTaken = 1; BranchTarget = 32'h200;
    step();
    BranchTaken = 0; Jump = 1; JumpTarget = 32'h300;
    step();
    Jump = 0; PCWrite = 1;
    step();
    chk("overwrite_pc", PC, 32'h300);
    PCWrite = 0; BranchTaken = 1; BranchTarget = 32'h500;
    step();
    BranchTaken = 0; Jump = 1; JumpTarget = 32'h600; PCWrite = 1;
    step();
    chk("supersede_pc", PC, 32'h600);
    chk("supersede_pend", 32'(RedirectPending), 32'h0);
    chk("scnt7", 32'(StallCount), 32'h7);
    Jump = 0;

    // Watchdog: 7 frozen edges quiet, 8th sets, stays set after release
    PCWrite = 0;
    step(7);
    chk("wd_7", 32'(StallTimeout), 32'h0);
    step();
    chk("wd_8", 32'(StallTimeout), 32'h1);
    PCWrite = 1;
    step();
    chk("wd_sticky", 32'(StallTimeout), 32'h1);

    // Asynchronous reset in the middle of a frozen run with a pending redirect
    do_reset();
    PCWrite = 0; BranchTaken = 1; BranchTarget = 32'h7000;
    step(5);
    chk("pre_rst_scnt", 32'(StallCount), 32'h5);
    chk("pre_rst_pend", 32'(RedirectPending), 32'h1);
    #2 Rst = 1'b0;
    #1;
    chk_reset_state("async_rst");
    step();
    Rst = 1'b1;
    idle_inputs();
    // Same again after the timeout has fired
    PCWrite = 0; BranchTaken = 1; BranchTarget = 32'h9000;
    step(9);
    chk("pre_rst2_tmo", 32'(StallTimeout), 32'h1);
    #2 Rst = 1'b0;
    #1;
    chk_reset_state("async_rst2");
    Rst = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ifid_hazard_responder.md
Name: ifid_hazard_responder

Overview:
- Consumer end of the hazard-detection control interface. It owns the PC register, the IF/ID pipeline register and the ID/EX control-bubble register.
- It applies PCWrite, IFID_Write, IF_Flush and stall_IDEX every cycle.
- It buffers branch/jump redirects that arrive while the PC is frozen.
- It keeps stall/flush statistics and a stuck-stall watchdog.
- Sits between instruction memory, the ID stage and the hazard-detection unit in the 5-stage MIPS datapath.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CTRL_W, 12, width of the ID-stage control bundle passed to ID/EX.
- MAX_STALL, 8, consecutive frozen cycles before StallTimeout sets.
- CNT_W, 16, width of the saturating statistics counters.

Ports:
- Clk  in  1  rising-edge clock.
- Rst  in  1  asynchronous, active-low reset.
- PCWrite  in  1  1 = PC may update this cycle.
- IFID_Write  in  1  1 = IF/ID may load this cycle.
- IF_Flush  in  1  1 = squash the instruction entering IF/ID.
- stall_IDEX  in  1  1 = inject a bubble (zero control) into ID/EX.
- Jump  in  1  jump redirect request from ID.
- BranchTaken  in  1  taken-branch redirect request from ID.
- JumpTarget  in  32  jump destination.
- BranchTarget  in  32  branch destination.
- Instr_in  in  32  instruction-memory read data at the current PC.
- ID_Ctrl  in  CTRL_W  decoded control for the instruction in ID.
- PC  out  32  current fetch address.
- IFID_Instr  out  32  IF/ID instruction.
- IFID_PCPlus4  out  32  IF/ID PC+4.
- IFID_Valid  out  1  0 = IF/ID holds a bubble.
- IDEX_Ctrl  out  CTRL_W  registered ID/EX control bundle.
- RedirectPending  out  1  a buffered redirect is waiting.
- StallCount  out  CNT_W  cycles with PCWrite=0.
- FlushCount  out  CNT_W  cycles with IF_Flush=1.
- StallTimeout  out  1  sticky watchdog flag.

Behaviour:
- Reset (Rst=0, asynchronous, any time including mid-stall) forces:
  - PC=RESET_PC, IFID_Instr=0, IFID_PCPlus4=0, IFID_Valid=0, IDEX_Ctrl=0;
  - redirect buffer empty (RedirectPending=0), StallCount=0, FlushCount=0, StallTimeout=0, frozen-run counter=0.
- Redirect request:
  - req = Jump | BranchTaken.
  - Target is JumpTarget if Jump=1, else BranchTarget (Jump has priority when both are high).
- Next PC on each rising edge:
  - PCWrite=1 and req=1: PC <= request target. Buffer is cleared (a live request supersedes a buffered one).
  - PCWrite=1, req=0, RedirectPending=1: PC <= buffered target, buffer cleared.
  - PCWrite=1 otherwise: PC <= PC+4. Mod 2^32 wrap: 32'hFFFF_FFFC -> 0.
  - PCWrite=0: PC holds. If req=1, the target is written into the buffer (overwrites any older entry) and RedirectPending=1.
- IF/ID register, in priority order:
  1. IF_Flush=1: IFID_Instr<=0 (nop), IFID_PCPlus4<=0, IFID_Valid<=0, regardless of IFID_Write.
  2. IFID_Write=1: IFID_Instr<=Instr_in, IFID_PCPlus4<=PC+4, IFID_Valid<=1.
  3. Otherwise all three hold.
- ID/EX control: IDEX_Ctrl <= 0 when stall_IDEX=1 or IFID_Valid=0; else IDEX_Ctrl <= ID_Ctrl. Single-cycle latency.
- Statistics:
  - StallCount increments on each edge with PCWrite=0.
  - FlushCount increments on each edge with IF_Flush=1.
  - Both saturate at all-ones and never wrap.
- Watchdog:
  - Frozen-run counter increments while PCWrite=0 and clears on any PCWrite=1 edge.
  - When it reaches MAX_STALL, StallTimeout sets on that edge.
  - StallTimeout stays set until reset.
- All outputs are registered. No combinational path from inputs to outputs.

Test Plan:
- Reset release, PCWrite=IFID_Write=1, Instr_in=32'h8C22_0004 -> PC steps 0,4,8. After the first edge IFID_Instr=32'h8C22_0004, IFID_PCPlus4=4, IFID_Valid=1.
- PC=8, PCWrite=IFID_Write=0 for 1 cycle, stall_IDEX=1 -> PC stays 8, IF/ID holds, IDEX_Ctrl=0, StallCount=1. Next cycle with stalls released, PC=12.
- PC=16, PCWrite=0, BranchTaken=1, BranchTarget=32'h40 for 1 cycle:
  - RedirectPending=1 and PC stays 16.
  - After 2 more frozen cycles, PCWrite=1 -> PC=32'h40, RedirectPending=0.
- Jump=1 with JumpTarget=32'h100 and BranchTaken=1 with BranchTarget=32'h80, with PCWrite=1, IF_Flush=1, IFID_Write=1 -> PC=32'h100, IFID_Valid=0, IFID_Instr=0, FlushCount incremented.
- PCWrite=0 held 8 cycles with MAX_STALL=8 -> StallTimeout=1 on the 8th edge and stays 1 after PCWrite returns to 1.
- Reset asserted mid-stall with RedirectPending=1 and StallCount=5 -> immediately PC=RESET_PC, RedirectPending=0, counters=0, IFID_Valid=0, StallTimeout=0.
